// File: rtl/rv_fetch_pkg.sv
// Shared types and sizing helpers for the RV32 instruction-fetch queue.
package rv_fetch_pkg;

   localparam int unsigned FETCH_XLEN  = 32;
   localparam int unsigned FETCH_ILEN  = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_ILEN-1:0] instr;
      logic                  filled;
   } fetch_entry_t;

   // Ring pointer width; DEPTH is a power of two so pointers wrap naturally.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Counter width able to hold the value DEPTH itself.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rv_fetch_queue_if.sv
// Fetch-queue bus: imem request/response, EX/WB control and the IF/ID handshake.
// RV_FETCH_PERF_EN adds the performance counter outputs.
interface rv_fetch_queue_if
   import rv_fetch_pkg::*;
#(
   parameter int unsigned XLEN  = FETCH_XLEN,
   parameter int unsigned ILEN  = FETCH_ILEN,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic             imem_req_valid;
   logic [XLEN-1:0]  imem_req_addr;
   logic             imem_req_ready;
   logic             imem_rsp_valid;
   logic [ILEN-1:0]  imem_rsp_data;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             halt;
   logic             out_valid;
   logic [XLEN-1:0]  out_pc;
   logic [ILEN-1:0]  out_instr;
   logic             out_ready;
   logic [CNT_W-1:0] occupancy;
`ifdef RV_FETCH_PERF_EN
   logic [31:0]      perf_stall_cycles;
   logic [31:0]      perf_flushes;
`endif

   // Fetch-queue side
   modport master (
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, halt, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
`ifdef RV_FETCH_PERF_EN
      , output perf_stall_cycles, perf_flushes
`endif
   );

   // Memory / pipeline side
   modport slave (
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, halt, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, occupancy
`ifdef RV_FETCH_PERF_EN
      , input perf_stall_cycles, perf_flushes
`endif
   );

endinterface

// File: rtl/rv_fetch_queue_ring.sv
// DEPTH-entry fetch ring: entries are allocated at tail, filled in order at the
// fill pointer and popped from head; flush empties the ring in one cycle.
module rv_fetch_ring
   import rv_fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = ptr_w(DEPTH),
   localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  alloc_i,
   input  logic [FETCH_XLEN-1:0] alloc_pc_i,
   input  logic                  fill_i,
   input  logic [FETCH_ILEN-1:0] fill_instr_i,
   input  logic                  pop_i,
   output logic [FETCH_XLEN-1:0] head_pc_o,
   output logic [FETCH_ILEN-1:0] head_instr_o,
   output logic                  head_filled_o,
   output logic [CNT_W-1:0]      count_o,
   output logic [CNT_W-1:0]      unfilled_o
);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q, fill_q;
   logic [CNT_W-1:0] count_q, unfilled_q;
   logic             do_fill, do_pop;

   // Guard against a fill with nothing outstanding and a pop of an unfilled head.
   assign do_fill = fill_i & (unfilled_q != '0);
   assign do_pop  = pop_i & head_filled_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         head_q     <= '0;
         tail_q     <= '0;
         fill_q     <= '0;
         count_q    <= '0;
         unfilled_q <= '0;
      end else begin
         if (alloc_i) begin
            mem_q[tail_q] <= '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
            tail_q        <= tail_q + PTR_W'(1);
         end
         if (do_fill) begin
            mem_q[fill_q].instr  <= fill_instr_i;
            mem_q[fill_q].filled <= 1'b1;
            fill_q               <= fill_q + PTR_W'(1);
         end
         if (do_pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q    <= count_q + CNT_W'(alloc_i) - CNT_W'(do_pop);
         unfilled_q <= unfilled_q + CNT_W'(alloc_i) - CNT_W'(do_fill);
      end
   end

   assign head_pc_o     = mem_q[head_q].pc;
   assign head_instr_o  = mem_q[head_q].instr;
   assign head_filled_o = (count_q != '0) & mem_q[head_q].filled;
   assign count_o       = count_q;
   assign unfilled_o    = unfilled_q;

endmodule

// File: rtl/rv_fetch_queue.sv
// RV32 fetch front end: PC generator, in-order imem request port and fetch ring.
// Define RV_FETCH_PERF_EN to add saturating stall and flush counters.
module rv_fetch_queue
   import rv_fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = FETCH_XLEN,
   parameter int unsigned     ILEN     = FETCH_ILEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic              clk,
   input logic              rst,
   rv_fetch_queue_if.master bus
);

   localparam int unsigned CNT_W = cnt_w(DEPTH);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0]      drop_q, drop_d;
   logic [CNT_W-1:0]      count, unfilled;
   logic [SUM_W-1:0]      inflight;
   logic [FETCH_XLEN-1:0] head_pc;
   logic [FETCH_ILEN-1:0] head_instr;
   logic                  head_filled;
   logic                  req_valid, accept, rsp_keep, out_valid, pop;

   // Entries held plus responses still owed to a flushed stream bound issue.
   assign inflight  = SUM_W'(count) + SUM_W'(drop_q);
   assign req_valid = rst & ~bus.halt & ~bus.redirect_valid & (inflight < SUM_W'(DEPTH));
   assign accept    = req_valid & bus.imem_req_ready;
   assign rsp_keep  = bus.imem_rsp_valid & (drop_q == '0) & ~bus.redirect_valid;
   assign out_valid = head_filled & ~bus.halt;
   assign pop       = out_valid & bus.out_ready & ~bus.redirect_valid;

   // Redirect replaces the PC and converts every outstanding request into a drop.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc & ~XLEN'(INSTR_BYTES - 1);
         drop_d     = drop_q + unfilled - CNT_W'(bus.imem_rsp_valid);
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
         end
         if (bus.imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   rv_fetch_ring #(
      .DEPTH (DEPTH)
   ) u_ring (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (bus.redirect_valid),
      .alloc_i       (accept),
      .alloc_pc_i    (FETCH_XLEN'(fetch_pc_q)),
      .fill_i        (rsp_keep),
      .fill_instr_i  (FETCH_ILEN'(bus.imem_rsp_data)),
      .pop_i         (pop),
      .head_pc_o     (head_pc),
      .head_instr_o  (head_instr),
      .head_filled_o (head_filled),
      .count_o       (count),
      .unfilled_o    (unfilled)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.out_valid      = out_valid;
   assign bus.out_pc         = (count != '0) ? XLEN'(head_pc) : '0;
   assign bus.out_instr      = (count != '0) ? ILEN'(head_instr) : '0;
   assign bus.occupancy      = count;

`ifdef RV_FETCH_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (!out_valid && !bus.halt && (perf_stall_q != '1)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (bus.redirect_valid && (perf_flush_q != '1)) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cycles = perf_stall_q;
   assign bus.perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue: per-cycle vector table plus async-reset sequence.
module tb_rv_fetch_queue;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rv_fetch_queue_if #(.XLEN(32), .ILEN(32), .DEPTH(4)) bus ();

   rv_fetch_queue #(
      .XLEN     (32),
      .ILEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h100)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst_before;
      int unsigned lat;
      bit          out_ready;
      bit          halt;
      bit          redir;
      logic [31:0] redir_pc;
      bit          exp_req_valid;
      logic [31:0] exp_req_addr;
      bit          exp_out_valid;
      logic [31:0] exp_out_pc;
      int unsigned exp_occ;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   vec_t        vecs[$];
   mreq_t       pend[$];
   int unsigned cyc = 0;
   int unsigned lat = 1;
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input bit rb, input int unsigned l, input bit o, input bit h, input bit r,
                      input logic [31:0] rp, input bit erv, input logic [31:0] ea,
                      input bit eov, input logic [31:0] ep, input int unsigned eo);
      vec_t v;
      v.rst_before = rb; v.lat = l; v.out_ready = o; v.halt = h; v.redir = r;
      v.redir_pc = rp; v.exp_req_valid = erv; v.exp_req_addr = ea;
      v.exp_out_valid = eov; v.exp_out_pc = ep; v.exp_occ = eo;
      vecs.push_back(v);
   endtask

   // Present the next in-order memory response whose latency has elapsed.
   task automatic drive_rsp();
      mreq_t m;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         m = pend.pop_front();
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(m.addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
   endtask

   task automatic tick();
      mreq_t m;
      @(negedge clk);
      if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
         m.addr = bus.imem_req_addr;
         m.due  = cyc + lat;
         pend.push_back(m);
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_rsp();
   endtask

   task automatic do_reset(input int unsigned l);
      rst = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.halt           = 1'b0;
      bus.out_ready      = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      pend.delete();
      lat = l;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " req_valid"}, 32'(bus.imem_req_valid), 32'd0);
      chk({tag, " req_addr"},  bus.imem_req_addr, 32'h100);
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " out_pc"},    bus.out_pc, 32'd0);
      chk({tag, " out_instr"}, bus.out_instr, 32'd0);
      chk({tag, " occupancy"}, 32'(bus.occupancy), 32'd0);
`ifdef RV_FETCH_PERF_EN
      chk({tag, " perf_stall"},   bus.perf_stall_cycles, 32'd0);
      chk({tag, " perf_flushes"}, bus.perf_flushes, 32'd0);
`endif
   endtask

   initial begin
      vec_t v;
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.halt           = 1'b0;
      bus.out_ready      = 1'b0;

      // Streaming, latency 1: two-cycle fill latency then one instruction per cycle
      add(1,1, 1,0,0,32'h0,   1,32'h100, 0,32'h000, 0);
      add(0,1, 1,0,0,32'h0,   1,32'h104, 0,32'h100, 1);
      add(0,1, 1,0,0,32'h0,   1,32'h108, 1,32'h100, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h10c, 1,32'h104, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h110, 1,32'h108, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h114, 1,32'h10c, 2);
      // Consumer stalled: exactly four requests, then drain in order and resume
      add(1,1, 0,0,0,32'h0,   1,32'h100, 0,32'h000, 0);
      add(0,1, 0,0,0,32'h0,   1,32'h104, 0,32'h100, 1);
      add(0,1, 0,0,0,32'h0,   1,32'h108, 1,32'h100, 2);
      add(0,1, 0,0,0,32'h0,   1,32'h10c, 1,32'h100, 3);
      for (int k = 0; k < 6; k++) add(0,1, 0,0,0,32'h0, 0,32'h110, 1,32'h100, 4);
      add(0,1, 1,0,0,32'h0,   0,32'h110, 1,32'h100, 4);
      add(0,1, 1,0,0,32'h0,   1,32'h110, 1,32'h104, 3);
      add(0,1, 1,0,0,32'h0,   1,32'h114, 1,32'h108, 3);
      add(0,1, 1,0,0,32'h0,   1,32'h118, 1,32'h10c, 3);
      add(0,1, 1,0,0,32'h0,   1,32'h11c, 1,32'h110, 3);
      add(0,1, 1,0,0,32'h0,   1,32'h120, 1,32'h114, 3);
      // Latency 3, redirect (unaligned target) with two requests in flight
      add(1,3, 1,0,0,32'h0,   1,32'h100, 0,32'h000, 0);
      add(0,3, 1,0,0,32'h0,   1,32'h104, 0,32'h100, 1);
      add(0,3, 1,0,1,32'h202, 0,32'h108, 0,32'h100, 2);
      add(0,3, 1,0,0,32'h0,   1,32'h200, 0,32'h000, 0);
      add(0,3, 1,0,0,32'h0,   1,32'h204, 0,32'h200, 1);
      add(0,3, 1,0,0,32'h0,   1,32'h208, 0,32'h200, 2);
      add(0,3, 1,0,0,32'h0,   1,32'h20c, 0,32'h200, 3);
      add(0,3, 1,0,0,32'h0,   0,32'h210, 1,32'h200, 4);
      add(0,3, 1,0,0,32'h0,   1,32'h210, 1,32'h204, 3);
      // Redirect coinciding with a response and a pop
      add(1,1, 1,0,0,32'h0,   1,32'h100, 0,32'h000, 0);
      add(0,1, 1,0,0,32'h0,   1,32'h104, 0,32'h100, 1);
      add(0,1, 1,0,1,32'h300, 0,32'h108, 1,32'h100, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h300, 0,32'h000, 0);
      add(0,1, 1,0,0,32'h0,   1,32'h304, 0,32'h300, 1);
      add(0,1, 1,0,0,32'h0,   1,32'h308, 1,32'h300, 2);
      // Halt for five cycles with entries held; a response lands during halt
      add(1,1, 0,0,0,32'h0,   1,32'h100, 0,32'h000, 0);
      add(0,1, 0,0,0,32'h0,   1,32'h104, 0,32'h100, 1);
      for (int k = 0; k < 5; k++) add(0,1, 1,1,0,32'h0, 0,32'h108, 0,32'h100, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h108, 1,32'h100, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h10c, 1,32'h104, 2);
      add(0,1, 1,0,0,32'h0,   1,32'h110, 1,32'h108, 2);
      // Redirect while halted still flushes
      add(1,1, 1,0,0,32'h0,   1,32'h100, 0,32'h000, 0);
      add(0,1, 1,0,0,32'h0,   1,32'h104, 0,32'h100, 1);
      add(0,1, 1,1,1,32'h400, 0,32'h108, 0,32'h100, 2);
      add(0,1, 1,1,0,32'h0,   0,32'h400, 0,32'h000, 0);
      add(0,1, 1,0,0,32'h0,   1,32'h400, 0,32'h000, 0);
      add(0,1, 1,0,0,32'h0,   1,32'h404, 0,32'h400, 1);
      add(0,1, 1,0,0,32'h0,   1,32'h408, 1,32'h400, 2);

      #1 rst = 1'b0;
      #1 chk_reset_outputs("initial_reset");

      foreach (vecs[i]) begin
         v = vecs[i];
         if (v.rst_before) do_reset(v.lat);
         bus.out_ready      = v.out_ready;
         bus.halt           = v.halt;
         bus.redirect_valid = v.redir;
         bus.redirect_pc    = v.redir_pc;
         #1;
         chk($sformatf("row%0d req_valid", i), 32'(bus.imem_req_valid), 32'(v.exp_req_valid));
         chk($sformatf("row%0d req_addr", i),  bus.imem_req_addr, v.exp_req_addr);
         chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(v.exp_out_valid));
         chk($sformatf("row%0d out_pc", i),    bus.out_pc, v.exp_out_pc);
         chk($sformatf("row%0d occupancy", i), 32'(bus.occupancy), v.exp_occ);
         if (v.exp_out_valid)
            chk($sformatf("row%0d out_instr", i), bus.out_instr, mem_word(v.exp_out_pc));
         else if (v.exp_occ == 0)
            chk($sformatf("row%0d out_instr", i), bus.out_instr, 32'd0);
         tick();
      end

      // Asynchronous reset between clock edges in the middle of a burst
      do_reset(1);
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("burst_before_reset out_valid", 32'(bus.out_valid), 32'd1);
      #2 rst = 1'b0;
      #1 chk_reset_outputs("async_reset");
      pend.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("restart c0 req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("restart c0 req_addr",  bus.imem_req_addr, 32'h100);
      chk("restart c0 occupancy", 32'(bus.occupancy), 32'd0);
      tick();
      #1;
      chk("restart c1 req_addr",  bus.imem_req_addr, 32'h104);
      chk("restart c1 occupancy", 32'(bus.occupancy), 32'd1);
      tick();
      #1;
      chk("restart c2 out_valid", 32'(bus.out_valid), 32'd1);
      chk("restart c2 out_pc",    bus.out_pc, 32'h100);
      chk("restart c2 out_instr", bus.out_instr, mem_word(32'h100));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rv_fetch_queue.md
Name: rv_fetch_queue

Overview:
Parametrised instruction-fetch front end for the RV32 pipeline. It replaces the bare PC register plus synchronous imem read with three parts: a PC generator, a ready/valid memory request port tolerating variable in-order latency, and a DEPTH-entry instruction queue. It feeds the IF/ID pipe register through a valid/ready handshake. Redirects from EX branch resolution and freezes from WB exceptions are handled in-block, and stale in-flight responses are discarded.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, queue entries plus max outstanding requests; power of 2, >=2
RESET_PC, 32'h0, PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address, bits[1:0] always 0
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid; responses return in request order, >=1 cycle after acceptance
imem_rsp_data  in  ILEN  fetched instruction
redirect_valid  in  1  taken branch/jump from EX
redirect_pc  in  XLEN  redirect target
halt  in  1  exception freeze from WB
out_valid  out  1  head instruction available
out_pc  out  XLEN  PC of head
out_instr  out  ILEN  head instruction
out_ready  in  1  IF/ID register consumes head (its !Stall_ID)
occupancy  out  $clog2(DEPTH+1)  allocated entries

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; all pointers, occupancy and drop_cnt = 0; imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
- Allocation: an entry is allocated at request acceptance (req_valid & req_ready), storing pc and filled=0. Then fetch_pc += 4, wrapping modulo 2^XLEN.
- imem_req_valid = !halt & !redirect_valid & (occupancy + drop_cnt < DEPTH). imem_req_addr = fetch_pc. Once asserted, valid/addr hold until ready, unless a redirect or halt occurs.
- Fill: a response with drop_cnt==0 writes the oldest unfilled entry and sets filled=1. A response with drop_cnt>0 is discarded and drop_cnt decrements.
- Output: out_valid = head filled & !halt. out_pc/out_instr come from the head entry and are 0 when the queue is empty. Pop on out_valid & out_ready. Minimum latency from request acceptance to out_valid is response latency + 1 cycle (registered fill).
- Simultaneous pop and fill/alloc in the same cycle are all legal. occupancy is updated by +alloc -pop.
- Full: occupancy + drop_cnt == DEPTH blocks new requests. Responses can never overflow the queue.
- Redirect (highest priority): all entries are flushed, the same-cycle pop is suppressed and no request issues.
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt <= drop_cnt + unfilled_entries, minus 1 if a response arrives this cycle with drop_cnt==0; that response is discarded.
  - The first request at the new PC issues the next cycle.
- Redirect during halt: the flush is still performed.
- Halt: no requests issue and no pops occur. Responses are still accepted and filled/dropped normally. State is otherwise frozen.
- Pointer arithmetic: head, tail and fill pointers are $clog2(DEPTH) bits and wrap naturally. drop_cnt is $clog2(DEPTH+1) bits.

Optional Feature:
- Macro: RV_FETCH_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0], incremented each cycle with !out_valid & !halt, and perf_flushes[31:0], incremented per redirect. Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package rv_fetch_pkg holds:
  - typedef fetch_entry_t {pc, instr, filled};
  - constant INSTR_BYTES=4;
  - localparam functions for pointer widths.
- One sub-module, rv_fetch_ring: DEPTH-entry storage with tail (alloc), fill and head (pop) pointers, flush input and occupancy. PC/drop/request logic stays in rv_fetch_queue.

Test Plan:
- Reset, RESET_PC=32'h100, memory latency 1, always ready, out_ready=1 -> requests 0x100, 0x104, 0x108...; out_pc sequence identical, one per cycle after a 2-cycle fill latency; out_instr matches memory.
- out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued then req_valid=0 and occupancy=4. On release, pops 4 in order and resumes.
- Latency 3 memory, redirect to 32'h200 with 2 requests in flight -> the two late responses are dropped (drop_cnt 2->0), next out_pc=0x200, and no stale instruction appears.
- Redirect in the same cycle as a response and a pop -> the response is discarded, no pop occurs, queue is empty next cycle, and the request to the target issues one cycle later.
- halt=1 for 5 cycles with filled entries -> out_valid=0, no requests, occupancy constant. On halt=0, output resumes with the unchanged head PC.
- rst pulled low mid-burst (async, between edges) -> outputs are 0 immediately. After release, fetching restarts at RESET_PC. With RV_FETCH_PERF_EN, counters read 0.
